// File: rtl/kled_pkg.sv
// Shared mode encodings, timing defaults and LED helpers for the LED mode scheduler.
package kled_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PAUSE = 2'b11
    } mode_t;

    localparam logic [23:0] TICK_DEF = 24'd10_000_000;
    localparam logic [19:0] DEB_DEF  = 20'd1_000_000;

    function automatic logic [3:0] pos_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stable-level debounce and a one-cycle press pulse.
module key_debounce
    import kled_pkg::*;
#(
    parameter logic [19:0] DEB = DEB_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        lvl;
    logic        armed;
    logic [19:0] cnt;

    // Until the key has been seen stably released after reset, the counter measures
    // that release instead, so a key held through reset cannot produce a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            lvl   <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (!armed) begin
                if (sync1 && sync2) begin
                    if (cnt == DEB - 20'd1) begin
                        armed <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end else if (sync2 != lvl) begin
                if (cnt == DEB - 20'd1) begin
                    lvl   <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_mode_sched.sv
// Four-key LED mode scheduler: priority arbiter, mode FSM, step tick generator and LED datapath.
module led_mode_sched
    import kled_pkg::*;
#(
    parameter logic [23:0] TICK = TICK_DEF,
    parameter logic [19:0] DEB  = DEB_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [1:0] mode
);

    logic [3:0]  press;
    mode_t       state, state_nxt;
    mode_t       stored, stored_nxt;
    logic        dir, dir_nxt;
    logic        slow, slow_nxt;
    logic        phase, phase_nxt;
    logic [1:0]  pos, pos_nxt;
    logic [3:0]  led_nxt;
    logic [23:0] tcnt, tcnt_nxt;
    logic        running, tick, step;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEB(DEB)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .key   (key[i]),
            .press (press[i])
        );
    end

    assign mode = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MODE_IDLE;
            stored <= MODE_IDLE;
            dir    <= 1'b0;
            slow   <= 1'b0;
            phase  <= 1'b0;
            pos    <= '0;
            led    <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_nxt;
            stored <= stored_nxt;
            dir    <= dir_nxt;
            slow   <= slow_nxt;
            phase  <= phase_nxt;
            pos    <= pos_nxt;
            led    <= led_nxt;
            tcnt   <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stored_nxt = stored;
        dir_nxt    = dir;
        slow_nxt   = slow;
        phase_nxt  = phase;
        pos_nxt    = pos;
        led_nxt    = led;
        tcnt_nxt   = tcnt;

        running = (state == MODE_CHASE) || (state == MODE_BLINK);
        tick    = running && (tcnt == TICK - 24'd1);
        step    = tick && (!slow || phase);

        if (!running) begin
            tcnt_nxt  = '0;
            phase_nxt = 1'b0;
        end else if (tick) begin
            tcnt_nxt  = '0;
            phase_nxt = slow & ~phase;
        end else begin
            tcnt_nxt = tcnt + 24'd1;
        end

        // The if-chain is the fixed-priority arbiter; a winning key also swallows any step.
        if (press[0]) begin
            case (state)
                MODE_IDLE: begin
                    state_nxt = MODE_CHASE;
                    pos_nxt   = '0;
                    led_nxt   = pos_onehot(2'd0);
                end
                MODE_CHASE: begin
                    state_nxt = MODE_BLINK;
                    led_nxt   = '1;
                end
                default: begin
                    state_nxt = MODE_IDLE;
                    led_nxt   = '0;
                end
            endcase
        end else if (press[1]) begin
            dir_nxt = ~dir;
        end else if (press[2]) begin
            slow_nxt = ~slow;
        end else if (press[3]) begin
            if (running) begin
                stored_nxt = state;
                state_nxt  = MODE_PAUSE;
            end else if (state == MODE_PAUSE) begin
                state_nxt = stored;
            end
        end else if (step) begin
            if (state == MODE_CHASE) begin
                pos_nxt = dir ? pos - 2'd1 : pos + 2'd1;
                led_nxt = pos_onehot(pos_nxt);
            end else begin
                led_nxt = ~led;
            end
        end

        if (state_nxt != state) begin
            tcnt_nxt  = '0;
            phase_nxt = 1'b0;
        end
    end

endmodule
